// File: rtl/alu_multicycle.sv
// WIDTH-generic ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// shift-add unsigned multiplier, returned through a start/busy/done handshake.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [2:0]       ALUctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] answer,
  output logic             zerosignal,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                         OP_SLT = 3'b100, OP_SLL = 3'b101, OP_SRL = 3'b110, OP_MUL = 3'b111;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   r_answer;
  logic               r_zero;
  logic               r_ovf;
  logic               r_done;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHW-1:0]     w_shamt;
  logic               w_slt;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_ovf;
  logic               w_mul_last;

  assign w_sum      = input1 + input2;
  assign w_diff     = input1 - input2;
  assign w_shamt    = input2[SHW-1:0];
  assign w_slt      = $signed(input1) < $signed(input2);
  assign w_acc_next = r_acc + (r_b[0] ? r_a : {(2*WIDTH){1'b0}});
  assign w_mul_last = (r_cnt == LAST_CNT);

  // Single-cycle result and signed-overflow flag for the non-multiply ops
  always_comb begin
    w_alu_res = {WIDTH{1'b0}};
    w_alu_ovf = 1'b0;
    case (ALUctrl)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (w_sum[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) && (w_diff[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_AND:  w_alu_res = input1 & input2;
      OP_OR:   w_alu_res = input1 | input2;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLL:  w_alu_res = input1 << w_shamt;
      OP_SRL:  w_alu_res = input1 >> w_shamt;
      default: w_alu_res = {WIDTH{1'b0}};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && (ALUctrl == OP_MUL)) w_state_next = S_MUL;
        else                              w_state_next = S_IDLE;
      end
      S_MUL: begin
        if (w_mul_last) w_state_next = S_IDLE;
        else            w_state_next = S_MUL;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy       = (r_state == S_MUL);
    done       = r_done;
    answer     = r_answer;
    zerosignal = r_zero;
    overflow   = r_ovf;
  end

  // Datapath: result registers and multiplier iteration (multiplier bits LSB first)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= {SHW{1'b0}};
      r_a      <= {(2*WIDTH){1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_answer <= {WIDTH{1'b0}};
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (ALUctrl == OP_MUL)) begin
            r_a   <= {{WIDTH{1'b0}}, input1};
            r_b   <= input2;
            r_acc <= {(2*WIDTH){1'b0}};
            r_cnt <= {SHW{1'b0}};
          end else if (start) begin
            r_answer <= w_alu_res;
            r_zero   <= (w_alu_res == {WIDTH{1'b0}});
            r_ovf    <= w_alu_ovf;
            r_done   <= 1'b1;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + SHW'(1);
          if (w_mul_last) begin
            r_answer <= w_acc_next[WIDTH-1:0];
            r_zero   <= (w_acc_next[WIDTH-1:0] == {WIDTH{1'b0}});
            r_ovf    <= (w_acc_next[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            r_done   <= 1'b1;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

endmodule
